// File: rtl/arbiter_1_to_n_request_multicast.sv
`default_nettype none
// ============================================================================
//  Module   : arbiter_1_to_n_request_multicast
//  Purpose  : Buffers memory requests and multicasts each head entry to every
//             channel in its mask, serving each channel as soon as it is ready.
//             Optional per-channel delivery counters: ARBITER_1_TO_N_DELIVERY_COUNT_EN
//  Revision : 1.0 - initial release
// ============================================================================

package arbiter_1_to_n_request_multicast_pkg;

    typedef struct packed {
        logic        valid;
        logic [15:0] id_channel;
        logic [31:0] address;
        logic [31:0] data;
    } MemoryPacketRequest;

    typedef struct packed {
        logic rd_en;
    } FIFOStateSignalsInput;

    typedef struct packed {
        logic full;
        logic empty;
        logic valid;
        logic prog_full;
        logic wr_rst_busy;
        logic rd_rst_busy;
    } FIFOStateSignalsOutput;

endpackage

module arbiter_1_to_n_request_multicast
    import arbiter_1_to_n_request_multicast_pkg::*;
#(
    parameter int NUM_MEMORY_REQUESTOR = 4,
    parameter int FIFO_DEPTH           = 32,
    parameter int PROG_THRESH          = FIFO_DEPTH / 2,
    parameter int BROADCAST_MODE       = 0,
    parameter int SETUP_CYCLES         = 4
) (
    input  logic                  ap_clk,
    input  logic                  areset,
    input  MemoryPacketRequest    request_in,
    input  FIFOStateSignalsInput  fifo_request_signals_in [NUM_MEMORY_REQUESTOR],
    output FIFOStateSignalsOutput fifo_request_signals_out,
    output MemoryPacketRequest    request_out [NUM_MEMORY_REQUESTOR],
    output logic                  fifo_setup_signal,
    output logic                  overflow,
    output logic [31:0]           delivery_count [NUM_MEMORY_REQUESTOR]
);

    localparam int c_N  = NUM_MEMORY_REQUESTOR;
    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_SW = $clog2(SETUP_CYCLES + 1);

    localparam logic [c_CW-1:0] c_FULL_CNT   = c_CW'(FIFO_DEPTH);
    localparam logic [c_CW-1:0] c_PROG_CNT   = c_CW'(PROG_THRESH);
    localparam logic [c_SW-1:0] c_SETUP_LAST = c_SW'(SETUP_CYCLES - 1);

    localparam logic [0:0] c_ST_SETUP = 1'b0;
    localparam logic [0:0] c_ST_RUN   = 1'b1;

    logic                r_rst;
    logic [0:0]          r_state;
    logic [0:0]          w_state_next;
    logic [c_SW-1:0]     r_setup_cnt;
    logic                w_setup_done;
    logic                r_setup;

    MemoryPacketRequest  r_req;
    logic [c_N-1:0]      r_rd_en;
    logic [c_N-1:0]      w_in_rd_en;
    logic [c_N-1:0]      w_in_mask;

    logic                r_wr_valid;
    MemoryPacketRequest  r_wr_data;
    logic [c_N-1:0]      r_wr_mask;

    MemoryPacketRequest  r_mem      [FIFO_DEPTH];
    logic [c_N-1:0]      r_mask_mem [FIFO_DEPTH];
    logic [c_AW-1:0]     r_wr_ptr;
    logic [c_AW-1:0]     r_rd_ptr;
    logic [c_CW-1:0]     r_count;
    logic [c_N-1:0]      r_delivered;
    logic                r_overflow;

    MemoryPacketRequest  w_head;
    logic [c_N-1:0]      w_head_mask;
    logic [c_N-1:0]      w_pending;
    logic [c_N-1:0]      w_deliver;
    logic                w_not_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_push_req;
    logic                w_push;

    logic [c_N-1:0]      r_out_valid;
    MemoryPacketRequest  r_out_data;
    FIFOStateSignalsOutput r_status;
    logic                w_unused;

    // areset is retimed once; everything below resets on the retimed copy
    always_ff @(posedge ap_clk) begin
        r_rst <= areset;
    end

    // ---------------- setup / run state machine ----------------
    assign w_setup_done = (r_setup_cnt == c_SETUP_LAST);

    always_ff @(posedge ap_clk) begin
        if (r_rst) begin
            r_state     <= c_ST_SETUP;
            r_setup_cnt <= '0;
            r_setup     <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_setup <= (r_state == c_ST_SETUP);
            if (r_state == c_ST_SETUP && !w_setup_done) begin
                r_setup_cnt <= r_setup_cnt + c_SW'(1);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_SETUP: if (w_setup_done) w_state_next = c_ST_RUN;
            c_ST_RUN:   w_state_next = c_ST_RUN;
            default:    w_state_next = c_ST_SETUP;
        endcase
    end

    // ---------------- input stage ----------------
    always_comb begin
        w_in_rd_en = '0;
        for (int i = 0; i < c_N; i++) begin
            w_in_rd_en[i] = fifo_request_signals_in[i].rd_en;
        end
    end

    generate
        if (BROADCAST_MODE != 0) begin : g_bcast
            assign w_in_mask = '1;
        end else begin : g_mask
            assign w_in_mask = r_req.id_channel[c_N-1:0];
        end
    endgenerate

    always_ff @(posedge ap_clk) begin
        if (r_rst) begin
            r_req.valid <= 1'b0;
            r_rd_en     <= '0;
            r_wr_valid  <= 1'b0;
        end else begin
            r_req      <= request_in;
            r_rd_en    <= w_in_rd_en;
            // zero-mask requests and anything arriving in setup die here
            r_wr_valid <= (r_state == c_ST_RUN) && r_req.valid && (|w_in_mask);
        end
        r_wr_data <= r_req;
        r_wr_mask <= w_in_mask;
    end

    // ---------------- buffer and head dispatch ----------------
    assign w_not_empty = (r_count != '0);
    assign w_full      = (r_count == c_FULL_CNT);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_mask = r_mask_mem[r_rd_ptr];
    assign w_pending   = w_head_mask & ~r_delivered;
    assign w_deliver   = w_not_empty ? (w_pending & r_rd_en) : '0;
    assign w_pop       = w_not_empty && ((r_delivered | w_deliver) == w_head_mask);
    assign w_push_req  = !r_rst && r_wr_valid && (r_state == c_ST_RUN);
    assign w_push      = w_push_req && (!w_full || w_pop);

    always_ff @(posedge ap_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr]      <= r_wr_data;
            r_mask_mem[r_wr_ptr] <= r_wr_mask;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (r_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_delivered <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + c_AW'(1);
                r_delivered <= '0;
            end else begin
                r_delivered <= r_delivered | w_deliver;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_push_req && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ---------------- outputs ----------------
    always_ff @(posedge ap_clk) begin
        if (r_rst) begin
            r_out_valid <= '0;
            r_status    <= '{full: 1'b0, empty: 1'b1, valid: 1'b0, prog_full: 1'b0,
                             wr_rst_busy: 1'b1, rd_rst_busy: 1'b1};
        end else begin
            r_out_valid          <= w_deliver;
            r_status.full        <= w_full;
            r_status.empty       <= !w_not_empty;
            r_status.valid       <= w_not_empty;
            r_status.prog_full   <= (r_count >= c_PROG_CNT);
            r_status.wr_rst_busy <= (r_state == c_ST_SETUP);
            r_status.rd_rst_busy <= (r_state == c_ST_SETUP);
        end
        r_out_data <= w_head;
    end

    always_comb begin
        for (int i = 0; i < c_N; i++) begin
            request_out[i]       = r_out_data;
            request_out[i].valid = r_out_valid[i];
        end
    end

    assign fifo_request_signals_out = r_status;
    assign fifo_setup_signal        = r_setup;
    assign overflow                 = r_overflow;
    assign w_unused                 = r_out_data.valid;

`ifdef ARBITER_1_TO_N_DELIVERY_COUNT_EN
    logic [31:0] r_dcnt [c_N];

    always_ff @(posedge ap_clk) begin
        for (int i = 0; i < c_N; i++) begin
            if (r_rst) begin
                r_dcnt[i] <= '0;
            end else if (r_out_valid[i]) begin
                r_dcnt[i] <= r_dcnt[i] + 32'd1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < c_N; i++) begin
            delivery_count[i] = r_dcnt[i];
        end
    end
`else
    always_comb begin
        for (int i = 0; i < c_N; i++) begin
            delivery_count[i] = 32'd0;
        end
    end
`endif

endmodule

`default_nettype wire
